// File: rtl/fp_round_pack.sv
// fp_round_pack: final stage of the FPU add/sub datapath.
// Takes the exponent-update results, denormalizes one bit per cycle when an
// excess right shift is pending, rounds under one of four IEEE-754 modes and
// packs the single-precision word behind a valid/ready handshake.
module fp_round_pack #(
    parameter int MAX_SHIFT = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [7:0]  E_exponent_update,
    input  logic [26:0] sum,
    input  logic        max_exponent_z,
    input  logic        min_exponent_z,
    input  logic        underflow_flag,
    input  logic [9:0]  excessive_shift_left,
    input  logic [1:0]  rnd_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow_out,
    output logic        underflow_out,
    output logic        inexact_out
);

    localparam int CW = $clog2(MAX_SHIFT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t state, next_state;

    logic          sign_r;
    logic [7:0]    exp_r;
    logic [26:0]   sig_r;
    logic          sticky_acc;
    logic          uf_r;
    logic          min_r;
    logic [1:0]    mode_r;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_init;

    logic [23:0] keep;
    logic        guard;
    logic        sticky;
    logic        inexact;
    logic        inc;
    logic [24:0] rounded;
    logic [8:0]  exp_fin;
    logic [22:0] frac;
    logic        rnd_ovf;
    logic        tiny;

    // Overflow result depends only on sign and rounding direction.
    function automatic logic [31:0] pack_overflow(input logic s, input logic [1:0] m);
        logic [31:0] inf_w;
        logic [31:0] max_w;
        inf_w = {s, 8'hFF, 23'h000000};
        max_w = {s, 8'hFE, 23'h7FFFFF};
        case (m)
            2'b00:   pack_overflow = inf_w;
            2'b01:   pack_overflow = max_w;
            2'b10:   pack_overflow = s ? max_w : inf_w;
            default: pack_overflow = s ? inf_w : max_w;
        endcase
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Requests beyond MAX_SHIFT would only push zeros through sticky anyway.
    assign cnt_init = (excessive_shift_left > 10'(MAX_SHIFT)) ? CW'(MAX_SHIFT)
                                                               : excessive_shift_left[CW-1:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; a single bundle is in flight at a time.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (max_exponent_z)
                        next_state = DONE;
                    else if (underflow_flag && (excessive_shift_left != 10'd0))
                        next_state = SHIFT;
                    else
                        next_state = ROUND;
                end
            end
            SHIFT:   if (cnt == CW'(1)) next_state = ROUND;
            ROUND:   next_state = DONE;
            default: if (out_ready) next_state = IDLE;
        endcase
    end

    // Rounding of the (possibly denormalized) significand held in sig_r.
    always_comb begin
        keep    = sig_r[26:3];
        guard   = sig_r[2];
        sticky  = sig_r[1] | sig_r[0] | sticky_acc;
        inexact = guard | sticky;
        case (mode_r)
            2'b00:   inc = guard & (sticky | keep[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~sign_r & inexact;
            default: inc = sign_r & inexact;
        endcase
        rounded = {1'b0, keep} + {24'd0, inc};
        exp_fin = {1'b0, exp_r};
        frac    = rounded[22:0];
        if (rounded[24]) begin
            frac    = rounded[23:1];
            exp_fin = {1'b0, exp_r} + 9'd1;
        end else if ((exp_r == 8'd0) && rounded[23]) begin
            exp_fin = 9'd1;
        end
        rnd_ovf = (exp_fin >= 9'd255);
        // Denormal input or a forced denormalizing shift both mark a tiny result.
        tiny    = (exp_r == 8'd0) | min_r | uf_r;
    end

    // Capture, iterative denormalization and registered result/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r        <= 1'b0;
            exp_r         <= 8'd0;
            sig_r         <= 27'd0;
            sticky_acc    <= 1'b0;
            uf_r          <= 1'b0;
            min_r         <= 1'b0;
            mode_r        <= 2'b00;
            cnt           <= '0;
            result        <= 32'd0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
            inexact_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r     <= sign_in;
                        exp_r      <= E_exponent_update;
                        sig_r      <= sum;
                        sticky_acc <= 1'b0;
                        uf_r       <= underflow_flag;
                        min_r      <= min_exponent_z;
                        mode_r     <= rnd_mode;
                        cnt        <= cnt_init;
                        if (max_exponent_z) begin
                            result        <= pack_overflow(sign_in, rnd_mode);
                            overflow_out  <= 1'b1;
                            underflow_out <= 1'b0;
                            inexact_out   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sticky_acc <= sticky_acc | sig_r[0];
                    sig_r      <= {1'b0, sig_r[26:1]};
                    cnt        <= cnt - CW'(1);
                end
                ROUND: begin
                    if (rnd_ovf) begin
                        result        <= pack_overflow(sign_r, mode_r);
                        overflow_out  <= 1'b1;
                        underflow_out <= 1'b0;
                        inexact_out   <= 1'b1;
                    end else begin
                        result        <= {sign_r, exp_fin[7:0], frac};
                        overflow_out  <= 1'b0;
                        underflow_out <= tiny & inexact;
                        inexact_out   <= inexact;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: table of hand-derived vectors pushed
// through a scoreboard queue, plus backpressure and mid-shift reset sequences.
module tb_fp_round_pack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  E_exponent_update;
    logic [26:0] sum;
    logic        max_exponent_z;
    logic        min_exponent_z;
    logic        underflow_flag;
    logic [9:0]  excessive_shift_left;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow_out;
    logic        underflow_out;
    logic        inexact_out;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [26:0] sig;
        logic        maxz;
        logic        minz;
        logic        uf;
        logic [9:0]  shift;
        logic [1:0]  mode;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
        string       tag;
    } exp_t;

    localparam int NV = 20;
    vec_t vecs[NV];
    exp_t sb[$];
    int   lat_seen;

    fp_round_pack dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .sign_in              (sign_in),
        .E_exponent_update    (E_exponent_update),
        .sum                  (sum),
        .max_exponent_z       (max_exponent_z),
        .min_exponent_z       (min_exponent_z),
        .underflow_flag       (underflow_flag),
        .excessive_shift_left (excessive_shift_left),
        .rnd_mode             (rnd_mode),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .result               (result),
        .overflow_out         (overflow_out),
        .underflow_out        (underflow_out),
        .inexact_out          (inexact_out)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [26:0] g,
                                input logic mx, input logic mn, input logic u,
                                input logic [9:0] sh, input logic [1:0] m,
                                input logic [31:0] r, input logic o, input logic un,
                                input logic ix, input int l);
        vec_t v;
        v.sign = s;  v.exp = e;  v.sig = g;  v.maxz = mx; v.minz = mn; v.uf = u;
        v.shift = sh; v.mode = m; v.res = r; v.ovf = o;  v.unf = un;  v.inx = ix;
        v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Drive one bundle, wait for the capture edge and push its expectation.
    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        int guard_cnt;
        guard_cnt = 0;
        while (!in_ready && guard_cnt < 100) begin
            @(posedge clk); #1;
            guard_cnt++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        sign_in              = v.sign;
        E_exponent_update    = v.exp;
        sum                  = v.sig;
        max_exponent_z       = v.maxz;
        min_exponent_z       = v.minz;
        underflow_flag       = v.uf;
        excessive_shift_left = v.shift;
        rnd_mode             = v.mode;
        in_valid             = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.res = v.res; e.ovf = v.ovf; e.unf = v.unf; e.inx = v.inx; e.lat = v.lat; e.tag = tag;
        sb.push_back(e);
        lat_seen = 1;
        while (!out_valid && lat_seen < 100) begin
            @(posedge clk); #1;
            lat_seen++;
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT presents.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got output with empty queue, expected none");
            return;
        end
        e = sb.pop_front();
        check({e.tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({e.tag, " latency"}, 32'(lat_seen), 32'(e.lat));
        check({e.tag, " result"}, result, e.res);
        check({e.tag, " overflow"}, 32'(overflow_out), 32'(e.ovf));
        check({e.tag, " underflow"}, 32'(underflow_out), 32'(e.unf));
        check({e.tag, " inexact"}, 32'(inexact_out), 32'(e.inx));
    endtask

    // Complete the handshake and let the DUT return to IDLE.
    task automatic handoff();
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = mk(0, 8'h7F, 27'h4000000, 0, 0, 0, 10'd0,  2'b00, 32'h3F800000, 0, 0, 0, 2);
        vecs[1]  = mk(0, 8'h7F, 27'h400000C, 0, 0, 0, 10'd0,  2'b00, 32'h3F800002, 0, 0, 1, 2);
        vecs[2]  = mk(0, 8'h7F, 27'h400000C, 0, 0, 0, 10'd0,  2'b01, 32'h3F800001, 0, 0, 1, 2);
        vecs[3]  = mk(0, 8'h7F, 27'h7FFFFFC, 0, 0, 0, 10'd0,  2'b00, 32'h40000000, 0, 0, 1, 2);
        vecs[4]  = mk(0, 8'hFE, 27'h7FFFFFC, 0, 0, 0, 10'd0,  2'b00, 32'h7F800000, 1, 0, 1, 2);
        vecs[5]  = mk(0, 8'h00, 27'h4000000, 0, 1, 1, 10'd3,  2'b00, 32'h00100000, 0, 0, 0, 5);
        vecs[6]  = mk(0, 8'h00, 27'h4000000, 0, 1, 1, 10'd40, 2'b10, 32'h00000001, 0, 1, 1, 29);
        vecs[7]  = mk(1, 8'hFF, 27'h4000000, 1, 0, 0, 10'd0,  2'b01, 32'hFF7FFFFF, 1, 0, 1, 1);
        vecs[8]  = mk(1, 8'hFF, 27'h4000000, 1, 0, 0, 10'd0,  2'b00, 32'hFF800000, 1, 0, 1, 1);
        vecs[9]  = mk(1, 8'hFF, 27'h4000000, 1, 0, 0, 10'd0,  2'b11, 32'hFF800000, 1, 0, 1, 1);
        vecs[10] = mk(0, 8'hFF, 27'h4000000, 1, 0, 0, 10'd0,  2'b10, 32'h7F800000, 1, 0, 1, 1);
        vecs[11] = mk(0, 8'hFF, 27'h4000000, 1, 0, 0, 10'd0,  2'b11, 32'h7F7FFFFF, 1, 0, 1, 1);
        vecs[12] = mk(1, 8'h00, 27'h0000000, 0, 1, 0, 10'd0,  2'b00, 32'h80000000, 0, 0, 0, 2);
        vecs[13] = mk(0, 8'h7F, 27'h4000001, 0, 0, 0, 10'd0,  2'b10, 32'h3F800001, 0, 0, 1, 2);
        vecs[14] = mk(1, 8'h7F, 27'h4000001, 0, 0, 0, 10'd0,  2'b11, 32'hBF800001, 0, 0, 1, 2);
        vecs[15] = mk(0, 8'h7F, 27'h4000001, 0, 0, 0, 10'd0,  2'b11, 32'h3F800000, 0, 0, 1, 2);
        vecs[16] = mk(0, 8'h7F, 27'h4000004, 0, 0, 0, 10'd0,  2'b00, 32'h3F800000, 0, 0, 1, 2);
        vecs[17] = mk(0, 8'h00, 27'h3FFFFFC, 0, 1, 0, 10'd0,  2'b00, 32'h00800000, 0, 1, 1, 2);
        vecs[18] = mk(0, 8'h00, 27'h4000000, 0, 1, 1, 10'd1,  2'b00, 32'h00400000, 0, 0, 0, 3);
        vecs[19] = mk(1, 8'h00, 27'h4000000, 0, 1, 1, 10'd27, 2'b11, 32'h80000001, 0, 1, 1, 29);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sign_in = 1'b0;
        E_exponent_update = 8'h00;
        sum = 27'h0;
        max_exponent_z = 1'b0;
        min_exponent_z = 1'b0;
        underflow_flag = 1'b0;
        excessive_shift_left = 10'd0;
        rnd_mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {29'd0, overflow_out, underflow_out, inexact_out}, 32'd0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] table vectors");
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            checkOutput();
            handoff();
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(vecs[1], "bp");
        checkOutput();
        sign_in = 1'b1;
        max_exponent_z = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d result", k), result, 32'h3F800002);
            check($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);

        $display("[TB] reset during shift");
        sign_in = 1'b0;
        E_exponent_update = 8'h00;
        sum = 27'h4000000;
        max_exponent_z = 1'b0;
        min_exponent_z = 1'b1;
        underflow_flag = 1'b1;
        excessive_shift_left = 10'd20;
        rnd_mode = 2'b00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("shift busy in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst result", result, 32'd0);
        #1 rst = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL abandoned bundle: got out_valid 1, expected 0");
            end
        end
        applyStimulus(vecs[3], "post_rst");
        checkOutput();
        handoff();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Stage directly downstream of the exponent-update stage in the FPU add/sub datapath.
- Consumes the updated exponent, the normalized 27-bit significand, and the max/min-exponent, underflow and excess-shift indications.
- Denormalizes iteratively when an excess shift is pending, rounds under one of four IEEE-754 modes, and packs the final single-precision word.
- Uses a valid/ready handshake on both sides.

Parameters:
- MAX_SHIFT, 27, clamp on the iterative right-shift count; any larger request shifts the significand fully into sticky.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input bundle valid.
- in_ready  output  1  block can accept a bundle; high only in IDLE.
- sign_in  input  1  result sign.
- E_exponent_update  input  8  biased exponent from the exponent-update stage.
- sum  input  27  significand: [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- max_exponent_z  input  1  exponent overflowed.
- min_exponent_z  input  1  exponent is zero/denormal.
- underflow_flag  input  1  denormalizing shift required.
- excessive_shift_left  input  10  right-shift amount when underflow_flag=1.
- rnd_mode  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  32  packed IEEE-754 single.
- overflow_out  output  1  overflow flag.
- underflow_out  output  1  underflow flag.
- inexact_out  output  1  inexact flag.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1; out_valid=0; result, overflow_out, underflow_out, inexact_out all 0; shift counter and sticky cleared.
- Reset mid-operation abandons the bundle with no output.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE:
  - in_valid=1 captures all inputs; sticky_acc=0.
  - max_exponent_z=1 -> DONE, with the overflow result computed at capture.
  - underflow_flag=1 and shift>0 -> SHIFT; cnt=min(excessive_shift_left, MAX_SHIFT).
  - Otherwise -> ROUND.
- SHIFT:
  - Each cycle: sticky_acc |= sig[0]; sig = sig>>1 (0 in at [26]); cnt--.
  - Go to ROUND the cycle after cnt reaches 1.
  - Takes exactly min(n, 27) cycles.
- ROUND, one cycle:
  - keep=sig[26:3]; g=sig[2]; st=sig[1]|sig[0]|sticky_acc; inexact=g|st.
  - inc: RNE g&(st|keep[0]); RTZ 0; RUP ~sign&inexact; RDN sign&inexact.
  - t=keep+inc, 25 bits wide.
  - t[24]=1 -> frac=t[23:1], exp+1.
  - Else if exp==0 and t[23]=1 -> exp=1 (denormal rounded up to min normal).
  - Else frac=t[22:0].
  - Exponent reaching 255 after rounding is handled as overflow.
  - underflow_out = (exp==0 before rounding or underflow_flag) & inexact.
  - -> DONE.
- Overflow packing, from max_exponent_z or rounding carry:
  - RNE -> ±inf.
  - RTZ -> ±0x7F7FFFFF (max finite).
  - RUP -> +inf if sign=0, else -max finite.
  - RDN -> -inf if sign=1, else +max finite.
  - overflow_out=1; inexact_out=1.
- DONE:
  - out_valid=1; result and flags are registered and stable while out_valid=1 and out_ready=0.
  - out_ready=1 -> IDLE next cycle, out_valid=0. No bypass: a new input is accepted one cycle after handoff.
- Latency, from the capture edge to out_valid high:
  - 2 cycles without shift.
  - 2+min(n,27) cycles with shift.
  - 1 cycle for max_exponent_z.
- Throughput: one bundle in flight.
- Zero significand with exp 0 -> ±0, no flags.
- in_valid ignored outside IDLE.

Test Plan:
- sign 0, exp 0x7F, sum 0x4000000, RNE -> result 0x3F800000, all flags 0, out_valid 2 cycles after capture.
- exp 0x7F, sum 0x400000C (frac lsb=1, g=1), RNE -> 0x3F800002, inexact 1. Same with RTZ -> 0x3F800001, inexact 1.
- exp 0x7F, sum 0x7FFFFFC, RNE -> carry gives 0x40000000, inexact 1. Exp 0xFE, same sum -> 0x7F800000, overflow 1.
- underflow_flag 1, shift 3, exp 0, sum 0x4000000 -> 0x00100000, underflow 0, inexact 0, out_valid at cycle 5. Shift 40, RUP, sign 0 -> 27 SHIFT cycles, 0x00000001, underflow 1, inexact 1.
- max_exponent_z 1, sign 1: RTZ -> 0xFF7FFFFF; RNE -> 0xFF800000; RDN -> 0xFF800000. overflow 1 and inexact 1 in all three.
- Backpressure and reset:
  - Hold out_ready 0 for 10 cycles -> result stable, in_ready 0.
  - Assert rst during SHIFT -> immediately IDLE, in_ready 1, out_valid 0; next bundle processes correctly.
